// File: rtl/controle_caixas.sv
// controle_caixas
// Box-handling controller placed after the dozen counter (0..12 wrap).
// When the registered item count reaches 12 it stops the conveyor and runs
// a req/ack handshake with the sealing station. It tallies sealed boxes and
// blocks the line once storage holds MAX_CAIXAS boxes. A count of 13..15
// latches a sticky fault that only reset clears.
//
// Ports:
//   clock          in   rising-edge system clock
//   reset          in   synchronous, active-high
//   contagem[3:0]  in   item count from the dozen counter
//   lacre_ack      in   sealing station done (level)
//   retirada       in   storage emptied (one-cycle pulse)
//   esteira        out  conveyor enable
//   lacre_req      out  seal request
//   caixa_cheia    out  high while a full box is being sealed
//   total_caixas   out  sealed boxes currently in storage
//   deposito_cheio out  storage full
//   erro           out  sticky fault flag
//
// Optional feature: define CONTROLE_CAIXAS_WATCHDOG_EN to add a seal-ack
// watchdog that forces the fault state after TIMEOUT cycles without ack.
module controle_caixas #(
  parameter int MAX_CAIXAS = 10,
  parameter int W_CAIXAS   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          contagem,
  input  logic                lacre_ack,
  input  logic                retirada,
  output logic                esteira,
  output logic                lacre_req,
  output logic                caixa_cheia,
  output logic [W_CAIXAS-1:0] total_caixas,
  output logic                deposito_cheio,
  output logic                erro
);

  if (MAX_CAIXAS < 1 || MAX_CAIXAS > (2 ** W_CAIXAS) - 1) begin : g_bad_max
    $error("controle_caixas: MAX_CAIXAS out of range for W_CAIXAS");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("controle_caixas: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    ENCHENDO,
    LACRANDO,
    AGUARDA_ZERO,
    BLOQUEADO,
    ERRO
  } state_t;

  state_t                state, state_next;
  logic [3:0]            cnt_r;
  logic [W_CAIXAS-1:0]   total_next;
  logic [W_CAIXAS-1:0]   total_inc;
  logic                  esteira_next, req_next, cheia_next, dep_next, erro_next;
  logic                  wd_expired;

  assign total_inc = total_caixas + W_CAIXAS'(1);

`ifdef CONTROLE_CAIXAS_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside LACRANDO, so it reads zero on the entry cycle;
  // saturates instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || state != LACRANDO) begin
      wd_cnt <= '0;
    end else if (wd_cnt != '1) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign wd_expired = (wd_cnt >= WD_W'(TIMEOUT));
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_next = state;
    total_next = total_caixas;

    if (state != ERRO && cnt_r >= 4'd13) begin
      state_next = ERRO;
    end else begin
      case (state)
        ENCHENDO: begin
          if (cnt_r == 4'd12) state_next = LACRANDO;
        end
        LACRANDO: begin
          if (lacre_ack) begin
            total_next = total_inc;
            state_next = (total_inc == W_CAIXAS'(MAX_CAIXAS)) ? BLOQUEADO : AGUARDA_ZERO;
          end else if (wd_expired) begin
            state_next = ERRO;
          end
        end
        AGUARDA_ZERO: begin
          if (cnt_r == 4'd0) state_next = ENCHENDO;
        end
        BLOQUEADO: begin
          if (retirada) begin
            total_next = '0;
            state_next = AGUARDA_ZERO;
          end
        end
        default: state_next = ERRO;
      endcase
    end

    // Outputs are decoded from the next state and registered with it,
    // giving Moore outputs aligned with the state register.
    esteira_next = 1'b0;
    req_next     = 1'b0;
    cheia_next   = 1'b0;
    dep_next     = 1'b0;
    erro_next    = 1'b0;
    case (state_next)
      ENCHENDO:     esteira_next = 1'b1;
      LACRANDO: begin
        req_next   = 1'b1;
        cheia_next = 1'b1;
      end
      AGUARDA_ZERO: esteira_next = 1'b1;
      BLOQUEADO:    dep_next     = 1'b1;
      default:      erro_next    = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ENCHENDO;
      cnt_r          <= '0;
      total_caixas   <= '0;
      esteira        <= 1'b1;
      lacre_req      <= 1'b0;
      caixa_cheia    <= 1'b0;
      deposito_cheio <= 1'b0;
      erro           <= 1'b0;
    end else begin
      state          <= state_next;
      cnt_r          <= contagem;
      total_caixas   <= total_next;
      esteira        <= esteira_next;
      lacre_req      <= req_next;
      caixa_cheia    <= cheia_next;
      deposito_cheio <= dep_next;
      erro           <= erro_next;
    end
  end

endmodule

// File: tb/tb_controle_caixas.sv
// Testbench for controle_caixas (MAX_CAIXAS=2, TIMEOUT=4).
// Inputs are driven at the falling edge; outputs are checked 1 time unit
// after the following rising edge.
module tb_controle_caixas;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] contagem;
  logic       lacre_ack;
  logic       retirada;
  logic       esteira, lacre_req, caixa_cheia, deposito_cheio, erro;
  logic [3:0] total_caixas;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  controle_caixas #(
    .MAX_CAIXAS(2),
    .W_CAIXAS  (4),
    .TIMEOUT   (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .contagem      (contagem),
    .lacre_ack     (lacre_ack),
    .retirada      (retirada),
    .esteira       (esteira),
    .lacre_req     (lacre_req),
    .caixa_cheia   (caixa_cheia),
    .total_caixas  (total_caixas),
    .deposito_cheio(deposito_cheio),
    .erro          (erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] cnt;
    logic       ack;
    logic       ret;
    logic       est;
    logic       req;
    logic       cheia;
    logic [3:0] tot;
    logic       dep;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic [3:0] c,
                     input logic a, input logic rt, input logic e_est,
                     input logic e_req, input logic e_ch, input logic [3:0] e_tot,
                     input logic e_dep, input logic e_err);
    vec_t v;
    v.name = nm; v.rst = r; v.cnt = c; v.ack = a; v.ret = rt;
    v.est = e_est; v.req = e_req; v.cheia = e_ch; v.tot = e_tot;
    v.dep = e_dep; v.err = e_err;
    vecs.push_back(v);
  endtask

  // One clock: drive, clock, compare every output.
  task automatic apply(input vec_t v);
    @(negedge clock);
    reset = v.rst; contagem = v.cnt; lacre_ack = v.ack; retirada = v.ret;
    @(posedge clock);
    #1;
    n_vec++;
    if ({esteira, lacre_req, caixa_cheia, total_caixas, deposito_cheio, erro} !==
        {v.est, v.req, v.cheia, v.tot, v.dep, v.err}) begin
      n_fail++;
      $display("FAIL %s: got est=%b req=%b cheia=%b tot=%0d dep=%b erro=%b, want est=%b req=%b cheia=%b tot=%0d dep=%b erro=%b",
               v.name, esteira, lacre_req, caixa_cheia, total_caixas, deposito_cheio, erro,
               v.est, v.req, v.cheia, v.tot, v.dep, v.err);
    end
  endtask

  initial begin
    reset = 1'b1; contagem = '0; lacre_ack = 1'b0; retirada = 1'b0;

    //   name            rst cnt ack ret | est req ch tot dep err
    add("reset",          1,  0, 0, 0,    1, 0, 0, 0, 0, 0);
    add("fill0",          0,  0, 0, 0,    1, 0, 0, 0, 0, 0);
    add("fill5",          0,  5, 0, 0,    1, 0, 0, 0, 0, 0);
    add("fill11",         0, 11, 0, 0,    1, 0, 0, 0, 0, 0);
    add("cnt12_edge1",    0, 12, 0, 0,    1, 0, 0, 0, 0, 0);
    add("cnt12_edge2",    0, 12, 0, 0,    0, 1, 1, 0, 0, 0);
    add("wait_ack1",      0, 12, 0, 0,    0, 1, 1, 0, 0, 0);
    add("wait_ack2",      0, 12, 0, 0,    0, 1, 1, 0, 0, 0);
    add("wait_ack3",      0, 12, 0, 0,    0, 1, 1, 0, 0, 0);
    add("wait_ack4",      0, 12, 0, 0,    0, 1, 1, 0, 0, 0);
    add("ack_seal1",      0, 12, 1, 0,    1, 0, 0, 1, 0, 0);
    add("ack_held",       0, 12, 1, 0,    1, 0, 0, 1, 0, 0);
    add("hold12_noreq",   0, 12, 0, 0,    1, 0, 0, 1, 0, 0);
    add("wrap0_a",        0,  0, 0, 0,    1, 0, 0, 1, 0, 0);
    add("wrap0_b",        0,  0, 0, 0,    1, 0, 0, 1, 0, 0);
    add("ret_ignored",    0,  0, 0, 1,    1, 0, 0, 1, 0, 0);
    add("cnt12_b1",       0, 12, 0, 0,    1, 0, 0, 1, 0, 0);
    add("second_req",     0, 12, 0, 0,    0, 1, 1, 1, 0, 0);
    add("ack_full",       0, 12, 1, 0,    0, 0, 0, 2, 1, 0);
    add("full_ack_ign",   0, 12, 1, 0,    0, 0, 0, 2, 1, 0);
    add("full_hold",      0, 12, 0, 0,    0, 0, 0, 2, 1, 0);
    add("retirada",       0, 12, 0, 1,    1, 0, 0, 0, 0, 0);
    add("after_ret",      0, 12, 0, 0,    1, 0, 0, 0, 0, 0);
    add("wrap0_c",        0,  0, 0, 0,    1, 0, 0, 0, 0, 0);
    add("wrap0_d",        0,  0, 0, 0,    1, 0, 0, 0, 0, 0);
    add("cnt13_edge1",    0, 13, 0, 0,    1, 0, 0, 0, 0, 0);
    add("cnt13_erro",     0,  0, 0, 0,    0, 0, 0, 0, 0, 1);
    add("erro_ack",       0,  0, 1, 0,    0, 0, 0, 0, 0, 1);
    add("erro_cnt12",     0, 12, 0, 0,    0, 0, 0, 0, 0, 1);
    add("erro_reset",     1,  0, 0, 0,    1, 0, 0, 0, 0, 0);
    add("mid_fill",       0, 12, 0, 0,    1, 0, 0, 0, 0, 0);
    add("mid_req",        0, 12, 0, 0,    0, 1, 1, 0, 0, 0);
    add("mid_ack",        0,  0, 1, 0,    1, 0, 0, 1, 0, 0);
    add("mid_wrap",       0,  0, 0, 0,    1, 0, 0, 1, 0, 0);
    add("mid_fill2",      0, 12, 0, 0,    1, 0, 0, 1, 0, 0);
    add("mid_req2",       0, 12, 0, 0,    0, 1, 1, 1, 0, 0);
    add("mid_reset",      1, 12, 0, 0,    1, 0, 0, 0, 0, 0);
    add("cnt15_agz_a",    0, 15, 0, 0,    1, 0, 0, 0, 0, 0);
    add("cnt15_erro",     0,  0, 0, 0,    0, 0, 0, 0, 0, 1);
    add("final_reset",    1,  0, 0, 0,    1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Watchdog: enter LACRANDO, then withhold ack. With the watchdog the
    // counter hits TIMEOUT=4 four edges after entry and erro rises one edge
    // later; without it the request simply persists.
    apply('{"wd_wrap", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    apply('{"wd_fill", 1'b0, 4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});
    apply('{"wd_enter", 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0});
    for (int k = 1; k <= 8; k++) begin
      vec_t w;
`ifdef CONTROLE_CAIXAS_WATCHDOG_EN
      if (k >= 5)
        w = '{"wd_timeout", 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
      else
        w = '{"wd_waiting", 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
`else
      w = '{"wd_absent_wait", 1'b0, 4'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
`endif
      apply(w);
    end
    apply('{"wd_reset", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
